// File: rtl/bsg_flow_credit_pkg.sv
// Shared definitions for the credit-based flow-control sender and receiver counters.
package bsg_flow_credit_pkg;

  localparam int unsigned els_default_lp = 64;

  // Counter width able to hold every value 0..els inclusive.
  function automatic int unsigned credit_cw_f(input int unsigned els);
    return $clog2(els + 1);
  endfunction

  localparam int unsigned cw_default_lp = credit_cw_f(els_default_lp);

  typedef logic [cw_default_lp-1:0] credit_count_t;

endpackage

// File: rtl/bsg_counter_up_down_sat.sv
// Up-by-constant / down-by-one counter that saturates at max_val_p and never wraps below zero.
module bsg_counter_up_down_sat
  import bsg_flow_credit_pkg::*;
#(
  parameter int unsigned max_val_p  = els_default_lp,
  parameter int unsigned init_val_p = max_val_p,
  parameter int unsigned up_step_p  = 1,
  parameter int unsigned width_p    = credit_cw_f(max_val_p)
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               up_i,
  input  logic               down_i,
  output logic [width_p-1:0] count_o,
  output logic               overflow_o
);

  localparam logic [width_p:0] step_lp = (width_p + 1)'(up_step_p);
  localparam logic [width_p:0] max_lp  = (width_p + 1)'(max_val_p);
  localparam logic [width_p:0] init_lp = (width_p + 1)'(init_val_p);

  logic [width_p-1:0] count_q, count_d;
  logic [width_p:0]   sum;
  logic               dec;

  // One extra bit so a full counter plus a step can be seen as exceeding max.
  always_comb begin
    dec        = down_i && (count_q != '0);
    sum        = {1'b0, count_q} + (up_i ? step_lp : '0) - {{width_p{1'b0}}, dec};
    overflow_o = sum > max_lp;
    count_d    = overflow_o ? max_lp[width_p-1:0] : sum[width_p-1:0];
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) count_q <= init_lp[width_p-1:0];
    else            count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/bsg_flow_credit_sender.sv
// Credit-based flow-control sender: launches data while credits are held, refills on token_i.
// Define BSG_FLOW_CREDIT_ERROR_CHECK_EN to build the sticky overflow error flag.
module bsg_flow_credit_sender
  import bsg_flow_credit_pkg::*;
#(
  parameter  int unsigned els_p                  = els_default_lp,
  parameter  int unsigned lg_credit_decimation_p = 0,
  localparam int unsigned cw_lp                  = credit_cw_f(els_p)
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             v_i,
  output logic             ready_o,
  output logic             v_o,
  input  logic             token_i,
  output logic [cw_lp-1:0] credit_count_o,
  output logic             idle_o,
  output logic             error_o
);

  localparam int unsigned token_val_lp = 1 << lg_credit_decimation_p;

  if ((els_p == 0) || ((els_p % token_val_lp) != 0)) begin : g_bad_cfg
    $error("els_p must be a nonzero multiple of 2**lg_credit_decimation_p");
  end

  logic [cw_lp-1:0] count;
  logic             send;
  logic             ovf;

  bsg_counter_up_down_sat #(
    .max_val_p (els_p),
    .init_val_p(els_p),
    .up_step_p (token_val_lp),
    .width_p   (cw_lp)
  ) u_count (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .up_i      (token_i),
    .down_i    (send),
    .count_o   (count),
    .overflow_o(ovf)
  );

  // ready_o comes from the register alone; reset also gates v_o combinationally.
  assign ready_o        = (count != '0);
  assign send           = v_i & ready_o & reset_n_i;
  assign v_o            = send;
  assign credit_count_o = count;
  assign idle_o         = (count == cw_lp'(els_p));

`ifdef BSG_FLOW_CREDIT_ERROR_CHECK_EN
  logic error_q, error_d;

  always_comb error_d = error_q | ovf;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
      if (ovf) $error("bsg_flow_credit_sender: credit overflow");
    end
  end

  assign error_o = error_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf;
  assign error_o    = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_flow_credit_sender.sv
// Directed and paired-receiver checks for bsg_flow_credit_sender (d=0 and d=2 instances).
module tb_bsg_flow_credit_sender;

  logic       clk_i = 1'b0;
  logic       reset_n_i;
  logic       v_i, token_i, ready_o, v_o, idle_o, error_o;
  logic [6:0] credit_count_o;
  logic       v2_i, tok2_i, ready2_o, v2_o, idle2_o, error2_o;
  logic [6:0] count2_o;

  int n_checks = 0;
  int n_fail   = 0;
  int rx       = 0;
  logic sent;
  logic exp_err;

  always #5 clk_i = ~clk_i;

  bsg_flow_credit_sender #(.els_p(64), .lg_credit_decimation_p(0)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .ready_o(ready_o), .v_o(v_o),
    .token_i(token_i), .credit_count_o(credit_count_o), .idle_o(idle_o), .error_o(error_o)
  );

  bsg_flow_credit_sender #(.els_p(64), .lg_credit_decimation_p(2)) dut2 (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v2_i), .ready_o(ready2_o), .v_o(v2_o),
    .token_i(tok2_i), .credit_count_o(count2_o), .idle_o(idle2_o), .error_o(error2_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
`ifdef BSG_FLOW_CREDIT_ERROR_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    reset_n_i = 1'b1; v_i = 1'b1; token_i = 1'b0; v2_i = 1'b0; tok2_i = 1'b0;
    #2 reset_n_i = 1'b0;
    #1;
    chk("rst count", credit_count_o, 64);
    chk("rst ready", ready_o, 1);
    chk("rst idle", idle_o, 1);
    chk("rst error", error_o, 0);
    chk("rst v_o", v_o, 0);
    tick(); tick();
    reset_n_i = 1'b1;
    #1;

    // drain all 64 credits
    for (int i = 0; i < 64; i++) begin
      chk("burst v_o", v_o, 1);
      chk("burst count", credit_count_o, 64 - i);
      tick();
    end
    chk("empty count", credit_count_o, 0);
    chk("empty ready", ready_o, 0);
    chk("empty v_o", v_o, 0);
    chk("empty idle", idle_o, 0);

    // single token refills one credit, one more send empties it again
    token_i = 1'b1; #1;
    chk("tok v_o blocked", v_o, 0);
    tick();
    token_i = 1'b0;
    chk("tok count", credit_count_o, 1);
    chk("tok ready", ready_o, 1);
    chk("tok v_o", v_o, 1);
    tick();
    chk("last send count", credit_count_o, 0);
    chk("last send ready", ready_o, 0);

    // send at count 1 with concurrent token keeps ready high
    token_i = 1'b1; tick();
    chk("refill count", credit_count_o, 1);
    chk("both v_o", v_o, 1);
    tick();
    chk("both count", credit_count_o, 1);
    chk("both ready", ready_o, 1);
    token_i = 1'b0; v_i = 1'b0;
    tick(); tick(); tick();
    chk("hold count", credit_count_o, 1);

    // refill to full, then overflow with one extra token
    token_i = 1'b1;
    for (int i = 0; i < 63; i++) tick();
    token_i = 1'b0;
    chk("full count", credit_count_o, 64);
    chk("full idle", idle_o, 1);
    chk("full error", error_o, 0);
    token_i = 1'b1; tick(); token_i = 1'b0;
    chk("ovf count", credit_count_o, 64);
    chk("ovf error", error_o, exp_err);
    tick();
    chk("ovf sticky", error_o, exp_err);
    chk("ovf idle", idle_o, 1);

    reset_n_i = 1'b0; #1;
    chk("rst clears error", error_o, 0);
    tick();
    reset_n_i = 1'b1;

    // reset mid-stream at count 5
    v_i = 1'b1;
    for (int i = 0; i < 59; i++) tick();
    chk("pre-rst count", credit_count_o, 5);
    chk("pre-rst v_o", v_o, 1);
    reset_n_i = 1'b0; #1;
    chk("async rst v_o", v_o, 0);
    chk("async rst count", credit_count_o, 64);
    chk("async rst ready", ready_o, 1);
    tick();
    reset_n_i = 1'b1; v_i = 1'b0;

    // decimation 2: each token is worth 4 credits
    v2_i = 1'b1;
    for (int i = 0; i < 54; i++) tick();
    chk("d2 count", count2_o, 10);
    tok2_i = 1'b1; #1;
    chk("d2 v_o", v2_o, 1);
    tick();
    chk("d2 send+tok", count2_o, 13);
    v2_i = 1'b0;
    tick();
    chk("d2 tok only", count2_o, 17);
    tok2_i = 1'b0;
    tick();
    chk("d2 hold", count2_o, 17);

    // random traffic against a receiver that returns one token per consumed element
    rx = 0;
    for (int i = 0; i < 2000; i++) begin
      v_i     = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      token_i = (rx > 0) && ($urandom_range(0, 1) == 1);
      #1;
      sent = v_o;
      chk("pair sum", 32'(credit_count_o) + 32'(rx), 64);
      tick();
      rx = rx + int'(sent) - int'(token_i);
    end
    v_i = 1'b0; token_i = 1'b0;
    chk("pair final", 32'(credit_count_o) + 32'(rx), 64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bsg_flow_credit_sender.md
BSG_FLOW_CREDIT_SENDER -- requirements
Module: bsg_flow_credit_sender

Interface
REQ-001 SHALL have parameter els_p, default 64: receiver buffer depth, i.e. the initial and maximum credit count.
REQ-002 SHALL have parameter lg_credit_decimation_p, default 0: each returned token is worth 2**lg_credit_decimation_p credits.
REQ-003 SHALL derive count width cw = clog2(els_p+1); cw = 7 at default.
REQ-004 SHALL have port clk_i, input, 1: sole clock, rising edge.
REQ-005 SHALL have port reset_n_i, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port v_i, input, 1: client has data to send.
REQ-007 SHALL have port ready_o, output, 1: at least one credit is held.
REQ-008 SHALL have port v_o, output, 1: data launched to the remote receiver this cycle.
REQ-009 SHALL have port token_i, input, 1: credit-return token from the receiver, one pulse per cycle max.
REQ-010 SHALL have port credit_count_o, output, cw: credits currently held.
REQ-011 SHALL have port idle_o, output, 1: all credits returned, credit_count_o == els_p.
REQ-012 SHALL have port error_o, output, 1: sticky credit-protocol violation.

Function
REQ-013 SHALL define send = v_i & ready_o; v_o SHALL equal send combinationally.
REQ-014 SHALL drive ready_o = (credit_count_o != 0), decoded from the register only, with no path from v_i.
REQ-015 SHALL, per clock: next = count - send + (token_i ? 2**lg_credit_decimation_p : 0).
REQ-016 SHALL, on simultaneous send and token_i, apply both in the same cycle; net change = 2**d - 1.
REQ-017 SHALL define overflow as next > els_p; on overflow the count SHALL saturate at els_p.
REQ-018 SHALL define underflow as send while count == 0; REQ-013 makes this impossible by construction, so it is not flagged.
REQ-019 SHALL make a send launched with count 1 drop ready_o on the following cycle, unless token_i was also asserted in that cycle.
REQ-020 SHALL hold credit_count_o unchanged with v_i=0 and token_i=0.
REQ-021 SHALL require els_p to be a nonzero multiple of 2**lg_credit_decimation_p (elaboration check).

Reset
REQ-022 SHALL, while reset_n_i=0, force credit_count_o=els_p, ready_o=1, idle_o=1 and error_o=0, asynchronously.
REQ-023 SHALL force v_o=0 during reset regardless of v_i.
REQ-024 SHALL, on reset asserted mid-transfer, discard all in-flight credit accounting; the receiver is reset by the same reset.
REQ-025 SHALL deassert reset synchronously to clk_i, as supplied by the integrator; the first send is legal on the first cycle after deassertion.

Configuration
REQ-026 SHALL gate the error feature with macro BSG_FLOW_CREDIT_ERROR_CHECK_EN.
- Defined: error_o sets on overflow (REQ-017) and holds until reset; a simulation-only $error SHALL fire on the same cycle.
- Undefined: error_o SHALL be tied 0 and no error logic SHALL be built; saturation per REQ-017 SHALL remain.

Structure
REQ-027 SHALL place shared package bsg_flow_credit_pkg holding the cw width function and a typedef for the credit-count vector; the flow_counter side SHALL reuse it.
REQ-028 SHALL instantiate one sub-module, bsg_counter_up_down_sat: up-by-constant, down-by-one, saturating at max_val_p, async active-low reset to init_val_p.

Verification
REQ-029 SHALL cover: reset; v_i=1 held 64 cycles, token_i=0 -> v_o high 64 cycles, count 0, ready_o=0 on cycle 65.
REQ-030 SHALL cover: count=0, token_i pulse with d=0 -> count 1, ready_o=1 next cycle, one further send allowed.
REQ-031 SHALL cover: count=10, v_i=1 and token_i=1 same cycle, d=2 -> count 13.
REQ-032 SHALL cover: idle (count 64), token_i pulse -> count stays 64, error_o=1 sticky (macro on) / error_o=0 (macro off).
REQ-033 SHALL cover: reset_n_i low mid-stream at count 5 -> count 64, v_o=0 immediately without waiting for a clock edge.
REQ-034 SHALL cover: random v_i/token_i paired with a bsg_flow_counter model -> sender count + receiver count == els_p every cycle.
